// File: rtl/result_queue_write_arbiter.sv
// result_queue_write_arbiter
//   Shares the single result-queue write port among NUM_REQ classifier engines.
//   A round-robin arbiter picks one detection per cycle. The detection is packed
//   as {scale, y, x} and held in a one-entry output register until the queue
//   has room. Detection runs are framed: the frame opens on frame_start, drains
//   on frame_end, and completion is reported to the sequencer with frame_done.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   frame_start    one-cycle pulse, opens a frame (honoured only in IDLE)
//   frame_end      one-cycle pulse, closes the frame (honoured only in RUN)
//   req_valid      per-engine detection valid
//   req_x/y/scale  per-engine detection fields, engine i at slice [i*W +: W]
//   req_ready      one-hot grant; a transfer happens on req_valid[i] && req_ready[i]
//   q_data         queue write data, packed {scale, y, x} with x in the LSBs
//   q_we           queue write enable (never asserted while q_full)
//   q_full         queue full flag
//   busy           high in RUN or DRAIN
//   frame_done     one-cycle pulse on return to IDLE after a drain
//   result_count   entries written this frame, saturating
module result_queue_write_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned X_BITS     = 10,
    parameter int unsigned Y_BITS     = 10,
    parameter int unsigned SCALE_BITS = 4,
    parameter int unsigned WIDTH      = X_BITS + Y_BITS + SCALE_BITS,
    parameter int unsigned CNT_BITS   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           frame_start,
    input  logic                           frame_end,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*X_BITS-1:0]      req_x,
    input  logic [NUM_REQ*Y_BITS-1:0]      req_y,
    input  logic [NUM_REQ*SCALE_BITS-1:0]  req_scale,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [WIDTH-1:0]               q_data,
    output logic                           q_we,
    input  logic                           q_full,
    output logic                           busy,
    output logic                           frame_done,
    output logic [CNT_BITS-1:0]            result_count
);

    localparam int unsigned PtrBits = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    state_e               state;
    logic                 hold_valid;
    logic [WIDTH-1:0]     hold_data;
    logic [PtrBits-1:0]   rr_ptr;

    logic                 can_accept;
    logic                 accept;
    logic                 found;
    logic [PtrBits-1:0]   winner;
    logic [PtrBits-1:0]   cand;
    logic [WIDTH-1:0]     sel_data;

    assign q_we       = hold_valid && !q_full;
    assign q_data     = hold_data;
    assign busy       = (state != StIdle);
    // A held entry leaving on this edge frees the register for a new accept.
    assign can_accept = (state == StRun) && (!hold_valid || q_we);
    assign accept     = can_accept && found;

    // Round-robin search starting just past the last winner, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand = PtrBits'((int'(rr_ptr) + k) % int'(NUM_REQ));
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Pack the winning engine's fields verbatim.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (winner == PtrBits'(i)) begin
                sel_data = {req_scale[i*SCALE_BITS +: SCALE_BITS],
                            req_y[i*Y_BITS +: Y_BITS],
                            req_x[i*X_BITS +: X_BITS]};
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            hold_valid   <= 1'b0;
            hold_data    <= '0;
            rr_ptr       <= '0;
            frame_done   <= 1'b0;
            result_count <= '0;
        end else begin
            frame_done <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (frame_start) begin
                        state <= StRun;
                    end
                end
                StRun: begin
                    if (frame_end) begin
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    if (!hold_valid) begin
                        state      <= StIdle;
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase

            // A new accept takes priority over the clear from a write.
            if (accept) begin
                hold_valid <= 1'b1;
                hold_data  <= sel_data;
                rr_ptr     <= winner;
            end else if (q_we) begin
                hold_valid <= 1'b0;
            end

            // The hold register is always empty in IDLE, so clear and increment never collide.
            if (state == StIdle && frame_start) begin
                result_count <= '0;
            end else if (q_we && (result_count != {CNT_BITS{1'b1}})) begin
                result_count <= result_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_result_queue_write_arbiter.sv
// Directed testbench for result_queue_write_arbiter. The main instance uses a
// 4-bit result counter so saturation is reachable; a second instance with the
// default 16-bit counter shares every input.
module tb_result_queue_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        frame_start;
    logic        frame_end;
    logic [3:0]  req_valid;
    logic [39:0] req_x;
    logic [39:0] req_y;
    logic [15:0] req_scale;
    logic        q_full;

    logic [3:0]  req_ready;
    logic [23:0] q_data;
    logic        q_we;
    logic        busy;
    logic        frame_done;
    logic [3:0]  result_count;

    logic [3:0]  req_ready16;
    logic [23:0] q_data16;
    logic        q_we16;
    logic        busy16;
    logic        frame_done16;
    logic [15:0] result_count16;

    int n_cmp;
    int n_bad;

    logic [9:0] ex [4];
    logic [9:0] ey [4];
    logic [3:0] es [4];

    result_queue_write_arbiter #(
        .NUM_REQ   (4),
        .X_BITS    (10),
        .Y_BITS    (10),
        .SCALE_BITS(4),
        .CNT_BITS  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .req_valid   (req_valid),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_scale   (req_scale),
        .req_ready   (req_ready),
        .q_data      (q_data),
        .q_we        (q_we),
        .q_full      (q_full),
        .busy        (busy),
        .frame_done  (frame_done),
        .result_count(result_count)
    );

    result_queue_write_arbiter dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .req_valid   (req_valid),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_scale   (req_scale),
        .req_ready   (req_ready16),
        .q_data      (q_data16),
        .q_we        (q_we16),
        .q_full      (q_full),
        .busy        (busy16),
        .frame_done  (frame_done16),
        .result_count(result_count16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] pack(input logic [9:0] x, input logic [9:0] y,
                                         input logic [3:0] s);
        return {s, y, x};
    endfunction

    task automatic set_eng(input int i, input logic [9:0] x, input logic [9:0] y,
                           input logic [3:0] s);
        req_x[i*10 +: 10]   = x;
        req_y[i*10 +: 10]   = y;
        req_scale[i*4 +: 4] = s;
    endtask

    task automatic load_table();
        for (int i = 0; i < 4; i++) begin
            set_eng(i, ex[i], ey[i], es[i]);
        end
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        int grants [8];
        logic [3:0] one_hot;
        n_cmp = 0;
        n_bad = 0;
        grants = '{1, 2, 3, 0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) begin
            ex[i] = 10'(100 + i);
            ey[i] = 10'(500 + 3 * i);
            es[i] = 4'(9 + i);
        end

        rst_n       = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        req_valid   = '0;
        req_x       = '0;
        req_y       = '0;
        req_scale   = '0;
        q_full      = 1'b0;

        // Reset values
        #2;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_q_we", 32'(q_we), 0);
        check("rst_q_data", 32'(q_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_count", 32'(result_count), 0);
        #20;
        rst_n = 1'b1;
        tick();

        // Single requester
        pulse_start();
        check("single_busy", 32'(busy), 1);
        check("single_count0", 32'(result_count), 0);
        set_eng(0, 10'd5, 10'd7, 4'd2);
        req_valid = 4'b0001;
        #1;
        check("single_ready", 32'(req_ready), 32'b0001);
        check("single_we_early", 32'(q_we), 0);
        tick();
        req_valid = '0;
        #1;
        check("single_we", 32'(q_we), 1);
        check("single_data", 32'(q_data), 32'({4'd2, 10'd7, 10'd5}));
        check("single_ready_idle", 32'(req_ready), 0);
        tick();
        check("single_we_off", 32'(q_we), 0);
        check("single_count1", 32'(result_count), 1);

        // Fairness: all four engines requesting, no backpressure
        load_table();
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            one_hot = 4'b0001 << grants[c];
            check($sformatf("fair_grant%0d", c), 32'(req_ready), 32'(one_hot));
            if (c > 0) begin
                check($sformatf("fair_data%0d", c), 32'(q_data),
                      32'(pack(ex[grants[c-1]], ey[grants[c-1]], es[grants[c-1]])));
            end
            tick();
        end
        req_valid = '0;
        #1;
        check("fair_last_we", 32'(q_we), 1);
        check("fair_last_data", 32'(q_data), 32'(pack(ex[0], ey[0], es[0])));
        tick();
        check("fair_count", 32'(result_count), 9);

        // Backpressure: rr_ptr=0 so engine 2 wins over nobody else
        req_valid = 4'b0100;
        #1;
        check("bp_ready_first", 32'(req_ready), 32'b0100);
        tick();
        q_full    = 1'b1;
        req_valid = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp_we%0d", c), 32'(q_we), 0);
            check($sformatf("bp_ready%0d", c), 32'(req_ready), 0);
            tick();
        end
        q_full = 1'b0;
        #1;
        check("bp_release_we", 32'(q_we), 1);
        check("bp_release_data", 32'(q_data), 32'(pack(ex[2], ey[2], es[2])));
        check("bp_release_ready", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        check("bp_next_we", 32'(q_we), 1);
        check("bp_next_data", 32'(q_data), 32'(pack(ex[3], ey[3], es[3])));
        tick();
        check("bp_idle_we", 32'(q_we), 0);
        check("bp_count", 32'(result_count), 11);

        // Drain with an entry stuck behind q_full
        req_valid = 4'b0001;
        #1;
        check("drain_accept_ready", 32'(req_ready), 32'b0001);
        tick();
        q_full    = 1'b1;
        frame_end = 1'b1;
        #1;
        check("drain_end_ready", 32'(req_ready), 0);
        tick();
        frame_end = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("drain_busy%0d", c), 32'(busy), 1);
            check($sformatf("drain_we%0d", c), 32'(q_we), 0);
            check($sformatf("drain_ready%0d", c), 32'(req_ready), 0);
            check($sformatf("drain_done%0d", c), 32'(frame_done), 0);
            tick();
        end
        q_full = 1'b0;
        #1;
        check("drain_write_we", 32'(q_we), 1);
        check("drain_write_data", 32'(q_data), 32'(pack(ex[0], ey[0], es[0])));
        check("drain_write_ready", 32'(req_ready), 0);
        tick();
        check("drain_empty_we", 32'(q_we), 0);
        check("drain_empty_done", 32'(frame_done), 0);
        check("drain_empty_busy", 32'(busy), 1);
        tick();
        check("drain_done_pulse", 32'(frame_done), 1);
        check("drain_busy_fall", 32'(busy), 0);
        check("drain_idle_ready", 32'(req_ready), 0);
        tick();
        check("drain_done_once", 32'(frame_done), 0);
        check("drain_count_hold", 32'(result_count), 12);
        req_valid = '0;

        // frame_end in IDLE does nothing
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check("idle_end_busy", 32'(busy), 0);
        tick();
        check("idle_end_done", 32'(frame_done), 0);
        check("idle_end_count", 32'(result_count), 12);

        // frame_start clears the counter; start+end together in RUN -> DRAIN
        pulse_start();
        check("restart_count", 32'(result_count), 0);
        check("restart_busy", 32'(busy), 1);
        frame_start = 1'b1;
        frame_end   = 1'b1;
        tick();
        frame_start = 1'b0;
        frame_end   = 1'b0;
        check("both_drain_busy", 32'(busy), 1);
        tick();
        check("both_done", 32'(frame_done), 1);
        check("both_idle", 32'(busy), 0);

        // Saturation: 20 writes
        pulse_start();
        req_valid = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            tick();
        end
        req_valid = '0;
        tick();
        check("sat_we_off", 32'(q_we), 0);
        check("sat_count4", 32'(result_count), 15);
        check("sat_count16", 32'(result_count16), 20);

        // Asynchronous reset with a held entry
        req_valid = 4'b0001;
        q_full    = 1'b1;
        tick();
        req_valid = '0;
        check("ar_held_we", 32'(q_we), 0);
        check("ar_held_busy", 32'(busy), 1);
        #2;
        q_full = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("ar_we", 32'(q_we), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_data", 32'(q_data), 0);
        check("ar_count", 32'(result_count), 0);
        check("ar_ready", 32'(req_ready), 0);
        check("ar_done", 32'(frame_done), 0);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("ar_post_we%0d", c), 32'(q_we), 0);
            check($sformatf("ar_post_done%0d", c), 32'(frame_done), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
